io_bank_ctrl: RTL and testbench
===============================

# io_bank_ctrl

Memory-mapped I/O bank for the MIPS32 SOC. It occupies the I/O slot that the memory decoder selects through `memEn[2]`/bank 2, and its `rdata` drives bank 2 of the read-data mux ahead of the read-data decoder. It contains a keyboard scan-code FIFO fed by an external key source and a free-running millisecond counter. Store data arrives already byte-lane encoded by the write-data encoder; load data leaves as a full word for the read-data decoder to slice.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: key FIFO entries. Must be a power of 2, range 2–16.
- `CLK_PER_MS`, default 50000: `clk` cycles per millisecond tick. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  bank select from the memory decoder.
- `memWrite`  in  4  byte-lane write enables; bit i covers `wdata[8i+7:8i]`.
- `addr`  in  11  word address (physical address bits 12:2). Only `addr[1:0]` is decoded; the upper bits mirror.
- `wdata`  in  32  encoded store data.
- `rdata`  out  32  read data; combinational.
- `keyCode`  in  8  scan code from the keyboard receiver.
- `keyValid`  in  1  one-cycle strobe; `keyCode` is valid while it is high.
- `keyIrq`  out  1  high while the FIFO is non-empty.

## Operation
- Access decode:
  - Write = `en & |memWrite`.
  - Read = `en & ~|memWrite`.
- Register map (`addr[1:0]`):
  - 0 KEY_STATUS
    - Read: bit0 notEmpty, bit1 full, bit2 overflow (sticky), bits[7:3] count, all other bits 0.
    - Write with lane 0 enabled and `wdata[2]=1`: clears overflow.
  - 1 KEY_DATA
    - Read: `{24'd0, head}`. A read with a non-empty FIFO pops one entry.
    - Read with an empty FIFO: returns 0 and pops nothing.
    - Write: ignored.
  - 2 MS_COUNT
    - Read: 32-bit millisecond count.
    - Write: loads only the enabled byte lanes and zeroes the prescaler.
  - 3 CONTROL
    - Read: returns 0.
    - Write with lane 0 enabled and `wdata[0]=1`: flushes the FIFO (count, pointers and overflow all go to 0).
- FIFO:
  - Circular buffer with read/write pointers of width log2(`FIFO_DEPTH`) that wrap naturally.
  - Count has width log2(`FIFO_DEPTH`)+1.
  - Push happens on `keyValid`.
- FIFO boundary rules:
  - Push while full with no pop in the same cycle: the code is dropped and overflow is set.
  - Push and pop in the same cycle while full: both take effect, count is unchanged, overflow is not set.
  - Push and pop in the same cycle while empty: the pop is ignored (the read returned 0), the push takes effect, count becomes 1.
  - Flush in the same cycle as a push: flush wins, the code is discarded, overflow stays 0.
- Timer:
  - The prescaler counts 0 … `CLK_PER_MS`−1. At the terminal value it returns to 0 and MS_COUNT increments.
  - MS_COUNT wraps from 0xFFFFFFFF to 0.
  - A write to MS_COUNT in the same cycle as a tick: the write wins and the tick is lost.
- Reset values:
  - FIFO empty, pointers 0, overflow 0.
  - Prescaler 0, MS_COUNT 0.
  - `keyIrq` 0; `rdata` 0 for every address.
  - FIFO storage contents are don't-care.

## Timing
- `rdata` is a combinational function of `addr` and current state, valid in the same cycle as `en`. This matches the single-cycle load path.
- The pop, register writes and flush all commit at the rising edge that ends the access cycle.
  - A KEY_DATA read returns the current head; the next cycle shows the next entry.
- The bank pops once per cycle in which it sees a read. If the CPU holds `en` across multiple cycles, it pops once per cycle.
- `keyIrq` and KEY_STATUS reflect a push starting in the cycle after the `keyValid` edge.
- `rst` has priority over every access and over `keyValid` in the same cycle.
- Asserting `rst` mid-sequence discards the queued keys and the count.
- The first MS tick occurs `CLK_PER_MS` cycles after `rst` is released.

## Test plan
Tests use `CLK_PER_MS=4` and `FIFO_DEPTH=8`.
- **Reset.** Assert `rst` 2 cycles, then read addresses 0..3 → all return 0 and `keyIrq`=0.
- **FIFO order and status.**
  - Push 0x1C, 0x32, 0x21 → KEY_STATUS = 0x19 and `keyIrq`=1.
  - Three KEY_DATA reads → 0x1C, 0x32, 0x21.
  - A fourth read → 0; then KEY_STATUS = 0 and `keyIrq`=0.
- **Full and overflow.**
  - Push 9 codes 0x01..0x09 → KEY_STATUS = 0x47.
  - Drain → 0x01..0x08 (0x09 was dropped).
  - Write 0x4 to KEY_STATUS → overflow clears (status = 0).
- **Full with simultaneous pop.**
  - Fill with 0x10..0x17, then `keyValid`(0xAA) together with a KEY_DATA read → the read returns 0x10, count stays 8, overflow stays 0.
  - Drain → 0x11..0x17, then 0xAA.
- **Flush against push.** Fill with 3 codes, then a CONTROL write of 0x1 in the same cycle as `keyValid`(0x55) → KEY_STATUS = 0 and a KEY_DATA read returns 0.
- **Timer.**
  - After 40 cycles from reset, MS_COUNT = 10.
  - Write 0xFFFFFFFF with `memWrite`=0xF → 4 cycles later MS_COUNT = 0 (wrap).
  - Write with `memWrite`=0x2 and `wdata`=0x0000AB00 → only byte 1 becomes 0xAB.

Source files
------------

// File: rtl/io_bank_ctrl.sv
// io_bank_ctrl: memory-mapped I/O bank holding a keyboard scan-code FIFO
// and a free-running millisecond counter. Read data is combinational so the
// single-cycle load path sees it in the same cycle as the bank select.
module io_bank_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_PER_MS = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  memWrite,
    input  logic [10:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  keyCode,
    input  logic        keyValid,
    output logic        keyIrq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PS_W  = $clog2(CLK_PER_MS);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PS_W-1:0]  PS_TERM  = PS_W'(CLK_PER_MS - 1);

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_DATA   = 2'd1;
    localparam logic [1:0] A_MS     = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [31:0]      ms_q, ms_d;

    logic wr_acc, rd_acc;
    logic full, not_empty;
    logic pop, push, flush, ovf_set, ovf_clr, ms_wr, tick;

    // Only the low two address bits decode; the rest mirror the map.
    logic addr_unused;
    assign addr_unused = ^addr[10:2];

    assign keyIrq = not_empty;

    // Access decode and the per-cycle FIFO/timer events derived from it.
    always_comb begin
        wr_acc    = en & (|memWrite);
        rd_acc    = en & ~(|memWrite);
        full      = (count_q == CNT_FULL);
        not_empty = (count_q != '0);
        pop       = rd_acc && (addr[1:0] == A_DATA) && not_empty;
        flush     = wr_acc && (addr[1:0] == A_CTRL) && memWrite[0] && wdata[0];
        ovf_clr   = wr_acc && (addr[1:0] == A_STATUS) && memWrite[0] && wdata[2];
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
        push      = keyValid && !flush && (!full || pop);
        ovf_set   = keyValid && !flush && full && !pop;
        ms_wr     = wr_acc && (addr[1:0] == A_MS);
        tick      = (presc_q == PS_TERM);
    end

    // Next-state for FIFO pointers, occupancy and the sticky overflow flag.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            if (ovf_set) begin
                ovf_d = 1'b1;
            end else if (ovf_clr) begin
                ovf_d = 1'b0;
            end
        end
    end

    // Next-state for the prescaler and millisecond counter; a write beats a tick.
    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        if (ms_wr) begin
            presc_d = '0;
            for (int i = 0; i < 4; i++) begin
                ms_d[8*i +: 8] = memWrite[i] ? wdata[8*i +: 8] : ms_q[8*i +: 8];
            end
        end else if (tick) begin
            presc_d = '0;
            ms_d    = ms_q + 32'd1;
        end else begin
            presc_d = presc_q + PS_W'(1);
        end
    end

    // Control and timer state, with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            presc_q  <= '0;
            ms_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
        end
    end

    // Scan-code storage; the write is gated by push, which already folds in flush.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; occupancy and pointers define what is valid.
        if (push) begin
            mem_q[wr_ptr_q] <= keyCode;
        end
    end

    // Combinational read mux; an empty KEY_DATA read returns 0.
    always_comb begin
        rdata = 32'd0;
        case (addr[1:0])
            A_STATUS: rdata = {24'd0, 5'(count_q), ovf_q, full, not_empty};
            A_DATA:   rdata = not_empty ? {24'd0, mem_q[rd_ptr_q]} : 32'd0;
            A_MS:     rdata = ms_q;
            default:  rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Self-checking bench for io_bank_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the bank.
module tb_io_bank_ctrl;

    localparam int DEPTH = 8;
    localparam int CPM   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  memWrite;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  keyCode;
    logic        keyValid;
    logic        keyIrq;

    always #5 clk = ~clk;

    io_bank_ctrl #(.FIFO_DEPTH(DEPTH), .CLK_PER_MS(CPM)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .memWrite (memWrite),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .keyCode  (keyCode),
        .keyValid (keyValid),
        .keyIrq   (keyIrq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_fifo[$];
    bit          m_ovf   = 1'b0;
    logic [31:0] m_base  = 32'd0;
    int          m_cyc   = 0;
    bit          m_valid = 1'b0;

    // Millisecond count = value at last load/reset plus whole periods elapsed since.
    function automatic logic [31:0] m_ms();
        return m_base + 32'(m_cyc / CPM);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: r = {24'd0, 5'(m_fifo.size()), m_ovf,
                       (m_fifo.size() == DEPTH), (m_fifo.size() != 0)};
            2'd1: r = (m_fifo.size() != 0) ? {24'd0, m_fifo[0]} : 32'd0;
            2'd2: r = m_ms();
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Model update at each rising edge from the inputs presented that cycle.
    always @(posedge clk) begin : model_upd
        logic [31:0] merged;
        bit          is_wr, is_rd, do_pop, do_flush, do_clr;
        if (rst) begin
            m_fifo.delete();
            m_ovf   = 1'b0;
            m_base  = 32'd0;
            m_cyc   = 0;
            m_valid = 1'b1;
        end else begin
            is_wr    = en && (memWrite != 4'd0);
            is_rd    = en && (memWrite == 4'd0);
            do_pop   = is_rd && (addr[1:0] == 2'd1) && (m_fifo.size() != 0);
            do_flush = is_wr && (addr[1:0] == 2'd3) && memWrite[0] && wdata[0];
            do_clr   = is_wr && (addr[1:0] == 2'd0) && memWrite[0] && wdata[2];
            if (do_flush) begin
                m_fifo.delete();
                m_ovf = 1'b0;
            end else begin
                if (do_pop) void'(m_fifo.pop_front());
                if (keyValid && m_fifo.size() == DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    if (keyValid) m_fifo.push_back(keyCode);
                    if (do_clr) m_ovf = 1'b0;
                end
            end
            if (is_wr && addr[1:0] == 2'd2) begin
                merged = m_ms();
                for (int b = 0; b < 4; b++)
                    if (memWrite[b]) merged[8*b +: 8] = wdata[8*b +: 8];
                m_base = merged;
                m_cyc  = 0;
            end else begin
                m_cyc++;
            end
        end
    end

    // Every-cycle comparison of both outputs against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("rdata_vs_model", rdata, m_rdata(addr[1:0]));
            check("keyIrq_vs_model", {31'd0, keyIrq}, {31'd0, (m_fifo.size() != 0)});
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] rv;
    logic        iv;

    task automatic step(input logic r, input logic e, input logic [3:0] mw,
                        input logic [10:0] a, input logic [31:0] wd,
                        input logic kv, input logic [7:0] kc);
        rst = r; en = e; memWrite = mw; addr = a; wdata = wd;
        keyValid = kv; keyCode = kc;
        @(negedge clk);
        rv = rdata;
        iv = keyIrq;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 11'd0, 32'd0, 1'b0, 8'd0);
    endtask

    task automatic push(input logic [7:0] code);
        step(1'b0, 1'b0, 4'd0, 11'd0, 32'd0, 1'b1, code);
    endtask

    // Upper address bits randomized to exercise the mirroring.
    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        step(1'b0, 1'b1, 4'd0, {9'($urandom), a}, 32'd0, 1'b0, 8'd0);
        check(name, rv, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        step(1'b0, 1'b1, be, {9'($urandom), a}, d, 1'b0, 8'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; memWrite = 4'd0; addr = 11'd0;
        wdata = 32'd0; keyValid = 1'b0; keyCode = 8'd0;
        @(posedge clk);
        #1;

        // Reset
        step(1'b1, 1'b0, 4'd0, 11'd0, 32'd0, 1'b1, 8'hEE);
        step(1'b1, 1'b0, 4'd0, 11'd0, 32'd0, 1'b0, 8'd0);
        for (int a = 0; a < 4; a++) begin
            rd_chk($sformatf("reset_rdata_a%0d", a), 2'(a), 32'd0);
            check("reset_keyIrq", {31'd0, iv}, 32'd0);
        end

        // FIFO order and status
        push(8'h1C); push(8'h32); push(8'h21);
        rd_chk("status_3", 2'd0, 32'h19);
        check("irq_3", {31'd0, iv}, 32'd1);
        rd_chk("pop_1C", 2'd1, 32'h1C);
        rd_chk("pop_32", 2'd1, 32'h32);
        rd_chk("pop_21", 2'd1, 32'h21);
        rd_chk("pop_empty", 2'd1, 32'd0);
        rd_chk("status_empty", 2'd0, 32'd0);
        check("irq_empty", {31'd0, iv}, 32'd0);

        // Full and overflow
        for (int i = 1; i <= 9; i++) push(8'(i));
        rd_chk("status_ovf", 2'd0, 32'h47);
        for (int i = 1; i <= 8; i++) rd_chk($sformatf("drain_%0d", i), 2'd1, 32'(i));
        rd_chk("status_ovf_only", 2'd0, 32'h04);
        wr(2'd0, 4'h1, 32'h4);
        rd_chk("status_ovf_clr", 2'd0, 32'd0);

        // Full with simultaneous pop
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        step(1'b0, 1'b1, 4'd0, 11'd1, 32'd0, 1'b1, 8'hAA);
        check("full_pop_read", rv, 32'h10);
        rd_chk("full_pop_status", 2'd0, 32'h43);
        for (int i = 1; i < 8; i++) rd_chk($sformatf("drain2_%0d", i), 2'd1, 32'h10 + 32'(i));
        rd_chk("drain2_AA", 2'd1, 32'hAA);

        // Flush against push
        push(8'h01); push(8'h02); push(8'h03);
        step(1'b0, 1'b1, 4'h1, 11'd3, 32'h1, 1'b1, 8'h55);
        rd_chk("flush_status", 2'd0, 32'd0);
        rd_chk("flush_data", 2'd1, 32'd0);

        // Timer
        step(1'b1, 1'b0, 4'd0, 11'd0, 32'd0, 1'b0, 8'd0);
        for (int i = 0; i < 40; i++) idle();
        rd_chk("ms_after_40", 2'd2, 32'd10);
        wr(2'd2, 4'hF, 32'hFFFF_FFFF);
        idle(); idle(); idle();
        rd_chk("ms_before_wrap", 2'd2, 32'hFFFF_FFFF);
        rd_chk("ms_wrap", 2'd2, 32'd0);
        wr(2'd2, 4'h2, 32'h0000_AB00);
        rd_chk("ms_lane1", 2'd2, 32'h0000_AB00);

        // Randomized traffic: busy-key phase then sparse-key phase
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                step(($urandom_range(0, 299) == 0),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0,
                     11'($urandom),
                     $urandom,
                     ($urandom_range(0, 99) < ((ph == 0) ? 45 : 6)),
                     8'($urandom));
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
